// File: rtl/aula_201029_qsys_nios2_qsys_rc_oci_dct_packer_if.sv
// Frame handshake between the DCT packer and its consumer.
// The packer drives the held frame; the consumer drives frame_ready.
interface aula_201029_qsys_nios2_qsys_rc_oci_dct_packer_if;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        frame_ready;

  modport master (
    output frame_valid,
    output frame_data,
    output frame_count,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  frame_count,
    output frame_ready
  );
endinterface

// File: rtl/aula_201029_qsys_nios2_qsys_rc_oci_dct_packer.sv
// Packs 3-bit trace codes into frames of up to MAX_ENTRIES entries.
// Define AULA_201029_QSYS_DCT_DROP_COUNT_EN to enable the drop counter.
module aula_201029_qsys_nios2_qsys_rc_oci_dct_packer #(
  parameter int MAX_ENTRIES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trc_on,
  input  logic        code_valid,
  input  logic [2:0]  code,
  input  logic        flush,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  aula_201029_qsys_nios2_qsys_rc_oci_dct_packer_if.master frm,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam logic [3:0] MAX_N = 4'(MAX_ENTRIES);

  typedef enum logic {
    ACCUM,
    STALL
  } state_t;

  state_t state, state_nx;

  logic [29:0] buf_nx, app_buf, frm_data_nx;
  logic [3:0]  cnt_nx, app_cnt, frm_cnt_nx;
  logic [29:0] fdata_q;
  logic [3:0]  fcount_q;
  logic        fvalid_q;
  logic        flush_pend, pend_nx;
  logic        frm_load;
  logic        slot_free, hit, accept, drop, flush_eff;

  assign slot_free = !fvalid_q || frm.frame_ready;
  assign hit       = trc_on && code_valid;
  // In STALL the code is only taken on the release cycle,
  // where it becomes entry 0 of the freshly cleared buffer.
  assign accept    = hit && (state == ACCUM || slot_free);
  assign drop      = hit && state == STALL && !slot_free;
  assign flush_eff = flush || flush_pend;

  assign frm.frame_valid = fvalid_q;
  assign frm.frame_data  = fdata_q;
  assign frm.frame_count = fcount_q;

  // Live buffer with this cycle's code appended.
  always_comb begin
    app_buf = dct_buffer;
    for (int i = 0; i < 10; i++) begin
      if (accept && dct_count == 4'(i)) begin
        app_buf[3*i +: 3] = code;
      end
    end
    app_cnt = dct_count + {3'd0, accept};
  end

  // Next state, buffer update and frame transfer decision.
  always_comb begin
    state_nx    = state;
    buf_nx      = dct_buffer;
    cnt_nx      = dct_count;
    pend_nx     = flush_pend;
    frm_load    = 1'b0;
    frm_data_nx = app_buf;
    frm_cnt_nx  = app_cnt;
    unique case (state)
      ACCUM: begin
        buf_nx = app_buf;
        cnt_nx = app_cnt;
        if (app_cnt == MAX_N) begin
          pend_nx = 1'b0;
          if (slot_free) begin
            frm_load = 1'b1;
            buf_nx   = '0;
            cnt_nx   = '0;
          end else begin
            state_nx = STALL;
          end
        end else if (flush_eff && app_cnt != 4'd0) begin
          if (slot_free) begin
            frm_load = 1'b1;
            buf_nx   = '0;
            cnt_nx   = '0;
            pend_nx  = 1'b0;
          end else begin
            pend_nx = 1'b1;
          end
        end
      end
      STALL: begin
        if (slot_free) begin
          frm_load    = 1'b1;
          frm_data_nx = dct_buffer;
          frm_cnt_nx  = dct_count;
          buf_nx      = {27'd0, accept ? code : 3'd0};
          cnt_nx      = {3'd0, accept};
          pend_nx     = 1'b0;
          state_nx    = (cnt_nx == MAX_N) ? STALL : ACCUM;
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  // Live buffer, pending flush and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dct_buffer <= buf_nx;
      dct_count  <= cnt_nx;
      flush_pend <= pend_nx;
      overflow   <= overflow | drop;
    end
  end

  // Held frame slot; a load wins over a handshake clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fvalid_q <= 1'b0;
      fdata_q  <= '0;
      fcount_q <= '0;
    end else if (frm_load) begin
      fvalid_q <= 1'b1;
      fdata_q  <= frm_data_nx;
      fcount_q <= frm_cnt_nx;
    end else if (frm.frame_ready) begin
      fvalid_q <= 1'b0;
    end
  end

`ifdef AULA_201029_QSYS_DCT_DROP_COUNT_EN
  logic [7:0] drop_q;

  // Saturating count of dropped codes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (drop && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule
